bist_response_analyzer: RTL and testbench

BIST_RESPONSE_ANALYZER -- requirements
Module: bist_response_analyzer

---
 rtl/radix_bist_pkg.sv | 6 +
 rtl/bist_response_analyzer_misr16.sv | 17 +
 rtl/bist_response_analyzer.sv | 72 +++++++
 tb/tb_bist_response_analyzer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/radix_bist_pkg.sv
// radix_bist_pkg: shared FSM states, MISR taps and result width for the BIST response analyzer
package radix_bist_pkg;
    localparam int RESULT_W = 16;
    localparam logic [RESULT_W-1:0] MISR_TAPS = 16'hD008;
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} bist_state_t;
endpackage

// File: rtl/bist_response_analyzer_misr16.sv
// misr16: 16-bit multiple-input signature register with taps 15,14,12,3
module misr16
    import radix_bist_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic [RESULT_W-1:0] data_in,
    output logic [RESULT_W-1:0] sig
);
    // shift with XOR feedback, then fold in the incoming result
    always_ff @(posedge clk) begin
        if (reset || clear) sig <= '0;
        else if (enable) sig <= {sig[RESULT_W-2:0], ^(sig & MISR_TAPS)} ^ data_in;
    end
endmodule

// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer: compacts N_PATTERNS multiplier results and compares against GOLDEN_SIG; BIST_SIGNATURE_OUT_EN exposes the live signature
module bist_response_analyzer
    import radix_bist_pkg::*;
#(
    parameter int                  N_PATTERNS = 64,
    parameter logic [RESULT_W-1:0] GOLDEN_SIG = 16'hA5C3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arm,
    input  logic [RESULT_W-1:0] result,
    input  logic                ready,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [7:0]          count
`ifdef BIST_SIGNATURE_OUT_EN
    ,
    output logic [RESULT_W-1:0] signature
`endif
);
    localparam logic [7:0] LAST = 8'(N_PATTERNS - 1);
    bist_state_t state, state_n;
    logic ready_q;
    logic [RESULT_W-1:0] sig;
    logic capture, clear, enable;
    assign capture = ready & ~ready_q;
    assign clear = arm && (state != COLLECT);
    assign enable = (state == COLLECT) && capture;
`ifdef BIST_SIGNATURE_OUT_EN
    assign signature = sig;
`endif
    misr16 u_misr (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .enable(enable),
        .data_in(result),
        .sig(sig)
    );
    // state register plus ready edge detector
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state <= state_n;
            ready_q <= ready;
        end
    end
    // next-state: arm starts from IDLE or DONE, last capture ends the run
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = arm ? COLLECT : IDLE;
            COLLECT: state_n = (enable && count == LAST) ? DONE : COLLECT;
            DONE:    state_n = arm ? COLLECT : DONE;
            default: state_n = IDLE;
        endcase
    end
    // capture counter, cleared at run start
    always_ff @(posedge clk) begin
        if (reset || clear) count <= '0;
        else if (enable) count <= count + 8'd1;
    end
    // outputs decoded from state; sig is frozen in DONE so the compare is stable
    always_comb begin
        busy = state == COLLECT;
        done = state == DONE;
        pass = (state == DONE) && (sig == GOLDEN_SIG);
    end
endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb_bist_response_analyzer: scoreboard bench driving three analyzer instances with shared directed stimulus
module tb_bist_response_analyzer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic arm = 1'b0;
    logic ready = 1'b0;
    logic [15:0] result = '0;
    logic [15:0] sg [3];
    logic [7:0] cn [3];
    logic bz [3];
    logic dn [3];
    logic ps [3];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int id;
        string name;
        logic [15:0] s;
        logic [7:0] c;
        logic b;
        logic d;
        logic p;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    bist_response_analyzer #(.N_PATTERNS(64), .GOLDEN_SIG(16'hA5C3)) u_a (
        .clk(clk), .reset(reset), .arm(arm), .result(result), .ready(ready),
        .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .count(cn[0])
`ifdef BIST_SIGNATURE_OUT_EN
        , .signature(sg[0])
`endif
    );
    bist_response_analyzer #(.N_PATTERNS(2), .GOLDEN_SIG(16'h0002)) u_b (
        .clk(clk), .reset(reset), .arm(arm), .result(result), .ready(ready),
        .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .count(cn[1])
`ifdef BIST_SIGNATURE_OUT_EN
        , .signature(sg[1])
`endif
    );
    bist_response_analyzer #(.N_PATTERNS(2), .GOLDEN_SIG(16'h0003)) u_c (
        .clk(clk), .reset(reset), .arm(arm), .result(result), .ready(ready),
        .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .count(cn[2])
`ifdef BIST_SIGNATURE_OUT_EN
        , .signature(sg[2])
`endif
    );
`ifndef BIST_SIGNATURE_OUT_EN
    assign sg[0] = u_a.sig;
    assign sg[1] = u_b.sig;
    assign sg[2] = u_c.sig;
`endif

    // monitor: every queued expectation is compared on the falling edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (sg[e.id] !== e.s || cn[e.id] !== e.c || bz[e.id] !== e.b ||
                dn[e.id] !== e.d || ps[e.id] !== e.p) begin
                errors++;
                $display("FAIL %s dut%0d: got sig=%h count=%0d busy=%b done=%b pass=%b, want sig=%h count=%0d busy=%b done=%b pass=%b",
                         e.name, e.id, sg[e.id], cn[e.id], bz[e.id], dn[e.id], ps[e.id],
                         e.s, e.c, e.b, e.d, e.p);
            end
        end
    end

    task automatic step(input logic rs, input logic ar, input logic rd, input logic [15:0] r);
        reset = rs;
        arm = ar;
        ready = rd;
        result = r;
        @(posedge clk);
        #1;
    endtask

    task automatic expect1(input int id, input string name, input logic [15:0] s,
                           input logic [7:0] c, input logic b, input logic d, input logic p);
        exp_t e;
        e.id = id;
        e.name = name;
        e.s = s;
        e.c = c;
        e.b = b;
        e.d = d;
        e.p = p;
        q.push_back(e);
    endtask

    task automatic expect_all(input string name, input logic [15:0] s, input logic [7:0] c,
                              input logic b, input logic d, input logic pb, input logic pc);
        expect1(0, name, s, c, b, d, 1'b0);
        expect1(1, name, s, c, b, d, pb);
        expect1(2, name, s, c, b, d, pc);
    endtask

    initial begin
        step(1, 0, 0, 16'h0000);
        step(1, 0, 0, 16'h0000);
        expect_all("reset", 16'h0000, 8'd0, 0, 0, 0, 0);
        step(0, 1, 1, 16'h00AA);
        expect_all("arm_with_edge", 16'h0000, 8'd0, 1, 0, 0, 0);
        step(0, 0, 0, 16'h0000);
        step(0, 0, 1, 16'h0001);
        expect_all("first_capture", 16'h0001, 8'd1, 1, 0, 0, 0);
        step(0, 0, 0, 16'h0000);
        step(0, 0, 1, 16'h0000);
        expect1(0, "second_capture", 16'h0002, 8'd2, 1, 0, 0);
        expect1(1, "done_pass", 16'h0002, 8'd2, 0, 1, 1);
        expect1(2, "done_fail", 16'h0002, 8'd2, 0, 1, 0);
        step(0, 0, 0, 16'h0000);
        repeat (20) step(0, 0, 1, 16'h0001);
        expect1(0, "ready_held", 16'h0005, 8'd3, 1, 0, 0);
        expect1(1, "done_ignores", 16'h0002, 8'd2, 0, 1, 1);
        expect1(2, "done_ignores", 16'h0002, 8'd2, 0, 1, 0);
        step(0, 1, 1, 16'h0001);
        expect1(0, "arm_in_collect", 16'h0005, 8'd3, 1, 0, 0);
        expect1(1, "arm_in_done", 16'h0000, 8'd0, 1, 0, 0);
        expect1(2, "arm_in_done", 16'h0000, 8'd0, 1, 0, 0);
        step(0, 0, 0, 16'h0000);
        step(0, 0, 1, 16'h8000);
        expect1(0, "msb_result", 16'h800A, 8'd4, 1, 0, 0);
        expect1(1, "rerun_first", 16'h8000, 8'd1, 1, 0, 0);
        expect1(2, "rerun_first", 16'h8000, 8'd1, 1, 0, 0);
        step(0, 0, 0, 16'h0000);
        step(0, 0, 1, 16'h0000);
        expect1(0, "feedback_cancel", 16'h0014, 8'd5, 1, 0, 0);
        expect1(1, "rerun_done_fail", 16'h0001, 8'd2, 0, 1, 0);
        expect1(2, "rerun_done_fail", 16'h0001, 8'd2, 0, 1, 0);
        step(0, 0, 0, 16'h0000);
        step(1, 0, 1, 16'h1234);
        expect_all("reset_over_edge", 16'h0000, 8'd0, 0, 0, 0, 0);
        step(0, 1, 0, 16'h0000);
        expect_all("arm_from_idle", 16'h0000, 8'd0, 1, 0, 0, 0);
        step(0, 0, 1, 16'h0001);
        expect_all("capture_before_abort", 16'h0001, 8'd1, 1, 0, 0, 0);
        step(1, 0, 0, 16'h0000);
        expect_all("abort", 16'h0000, 8'd0, 0, 0, 0, 0);
        step(0, 0, 0, 16'h0000);
        step(0, 0, 1, 16'h00FF);
        expect_all("idle_ignores", 16'h0000, 8'd0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
